stream_demux: RTL
=================

# stream_demux

Parametrised, registered 1-to-N stream demultiplexer for the memory_system datapath. It steers one WIDTH-bit input word per handshake to one of CHANNELS output channels chosen by a select field. Each channel has its own valid/ready handshake and a one-entry holding register, so a stalled channel never blocks words bound for other channels in later cycles. It replaces the combinational 8-bit and 1-bit demuxes wherever back-pressure or registered outputs are needed.

## Interface
- WIDTH, 8: data width per word (≥1).
- CHANNELS, 4: number of output channels (2..16).
- SEL_W, $clog2(CHANNELS): select width (derived; do not override).
- ZERO_IDLE, 1: 1 = out_data of a channel reads 0 whenever its out_valid is 0; 0 = it holds the last word.
- clk  in  1  single clock; all logic is rising-edge.
- rst_n  in  1  asynchronous, active-low reset; release is synchronised externally.
- in_valid  in  1  input word present.
- in_ready  out  1  block can accept the input word this cycle.
- in_data  in  WIDTH  input word.
- in_sel  in  SEL_W  destination channel index, qualified by in_valid.
- out_valid  out  CHANNELS  bit i = channel i holds a word.
- out_ready  in  CHANNELS  bit i = sink i accepts this cycle.
- out_data  out  CHANNELS*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- sel_err  out  1  one-cycle pulse: an out-of-range select was accepted and dropped.
- drop_count  out  8  saturating count of dropped words.

## Operation
- Input transfer occurs when in_valid && in_ready at a rising edge; output transfer on channel i when out_valid[i] && out_ready[i].
- Each channel is a two-state holder: EMPTY (out_valid=0) and FULL (out_valid=1, data stable).
- in_ready is combinational: 1 if in_sel ≥ CHANNELS (drop path), else 1 if channel in_sel is EMPTY or FULL with out_ready[in_sel]=1 (drain and refill in the same cycle).
- in_ready must not depend on in_valid, so sources may wait on in_ready.
- Accepted word with in_sel < CHANNELS: loaded into channel in_sel, which is FULL next cycle.
- Accepted word with in_sel ≥ CHANNELS (only possible when CHANNELS is not a power of two): discarded, sel_err pulses next cycle, drop_count increments and saturates at 255.
- Simultaneous drain and load on the same channel: channel stays FULL with the new word, with no bubble.
- Drains on other channels proceed independently in the same cycle as any load.
- Full throughput: one word per cycle sustained when sinks keep out_ready high.
- FULL channel data and out_valid are stable until drained, regardless of out_ready.
- Order is preserved per channel. Ordering across channels is not defined.
- Reset (asynchronous, any time including mid-transfer): all channels EMPTY, out_valid=0, out_data=0, sel_err=0, drop_count=0. Held words are lost.

## Timing
- Latency: input accept at edge k gives out_valid at cycle k+1.
- out_valid, out_data, sel_err and drop_count are registered outputs.
- in_ready is combinational from in_sel, out_ready and channel state only; there is no path from in_data.
- A stalled FULL channel with the same target blocks input (in_ready=0). A word for another channel is accepted immediately.
- ZERO_IDLE masking is applied after the register (AND with out_valid), so out_data stays glitch-free relative to out_valid.

## Structure
- Shared package demux_pkg: the channel state enum (CH_EMPTY, CH_FULL) and the DROP_CNT_W=8 constant.
- Sub-module demux_chan_reg (WIDTH): one-entry holder with load/drain inputs and the valid/data registers. The top instantiates it CHANNELS times with a generate loop and adds the select decode, drop path and counter.

## Test plan
- Reset/idle: assert rst_n=0 mid-stream with channel 2 FULL -> all out_valid=0, out_data=0 and drop_count=0 immediately, with no clock required.
- Basic steering: CHANNELS=4, send 0xA5 sel=2 with all out_ready=1 -> next cycle out_valid=4'b0100 and out_data[23:16]=0xA5. Other lanes read 0 with ZERO_IDLE=1.
- Back-pressure: out_ready[1]=0, send 0x11 then 0x22 to sel=1 -> second word stalls with in_ready=0. Raise out_ready[1] -> 0x11 drains and 0x22 loads in the same cycle, and 0x22 appears next cycle.
- Non-blocking: channel 0 FULL and stalled, send 0x33 sel=3 -> accepted at once, and out_valid=4'b1001.
- Drop path: CHANNELS=3, send sel=3 -> in_ready=1, sel_err pulses once, drop_count=1. After 300 drops, drop_count=255.
- Throughput: 64 random words with random sel and all ready=1 -> one accept per cycle, and per-channel order matches the scoreboard.

Source files
------------

// File: rtl/stream_demux_pkg.sv
// demux_pkg: shared channel-state type and counter width for stream_demux
package demux_pkg;
    localparam int DROP_CNT_W = 8;
    typedef enum logic {CH_EMPTY, CH_FULL} chan_state_t;
endpackage

// File: rtl/stream_demux_if.sv
// stream_demux_if: input stream, per-channel output streams and drop status
interface stream_demux_if #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4
);
    import demux_pkg::*;
    localparam int SEL_W = $clog2(CHANNELS);
    logic                      in_valid;
    logic                      in_ready;
    logic [WIDTH-1:0]          in_data;
    logic [SEL_W-1:0]          in_sel;
    logic [CHANNELS-1:0]       out_valid;
    logic [CHANNELS-1:0]       out_ready;
    logic [CHANNELS*WIDTH-1:0] out_data;
    logic                      sel_err;
    logic [DROP_CNT_W-1:0]     drop_count;
    modport master (
        output in_valid, in_data, in_sel, out_ready,
        input  in_ready, out_valid, out_data, sel_err, drop_count
    );
    modport slave (
        input  in_valid, in_data, in_sel, out_ready,
        output in_ready, out_valid, out_data, sel_err, drop_count
    );
endinterface

// File: rtl/stream_demux_chan_reg.sv
// demux_chan_reg: one-entry EMPTY/FULL holder with load and drain controls
module demux_chan_reg
    import demux_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             drain,
    input  logic [WIDTH-1:0] din,
    output logic             valid,
    output logic [WIDTH-1:0] data
);
    chan_state_t state, state_next;
    // holder state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= CH_EMPTY;
        else        state <= state_next;
    end
    // a load wins over a drain so a same-cycle drain and refill stays FULL
    always_comb begin
        state_next = state;
        state_next = load ? CH_FULL : (drain ? CH_EMPTY : state);
    end
    // word captured only on load, stable while FULL
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    data <= '0;
        else if (load) data <= din;
    end
    assign valid = (state == CH_FULL);
endmodule

// File: rtl/stream_demux.sv
// stream_demux: registered 1-to-N stream demultiplexer with per-channel back-pressure
module stream_demux
    import demux_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int CHANNELS  = 4,
    parameter bit ZERO_IDLE = 1
) (
    input logic            clk,
    input logic            rst_n,
    stream_demux_if.slave  bus
);
    localparam int SEL_W = $clog2(CHANNELS);
    logic [CHANNELS-1:0] hit, load, drain, valid;
    logic [WIDTH-1:0]    data [CHANNELS];
    logic                drop;
    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        assign hit[i]   = (bus.in_sel == SEL_W'(i));
        assign drain[i] = valid[i] & bus.out_ready[i];
        assign load[i]  = bus.in_valid & bus.in_ready & hit[i];
        demux_chan_reg #(.WIDTH(WIDTH)) u_chan (
            .clk   (clk),
            .rst_n (rst_n),
            .load  (load[i]),
            .drain (drain[i]),
            .din   (bus.in_data),
            .valid (valid[i]),
            .data  (data[i])
        );
        assign bus.out_data[i*WIDTH +: WIDTH] = ZERO_IDLE ? (data[i] & {WIDTH{valid[i]}}) : data[i];
    end
    // no hit means an out-of-range select, which is always accepted and dropped
    assign bus.in_ready  = ~|hit | |(hit & (~valid | bus.out_ready));
    assign bus.out_valid = valid;
    assign drop          = bus.in_valid & bus.in_ready & ~|hit;
    // drop pulse and saturating drop counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.sel_err    <= 1'b0;
            bus.drop_count <= '0;
        end else begin
            bus.sel_err <= drop;
            if (drop && bus.drop_count != '1) bus.drop_count <= bus.drop_count + 1'b1;
        end
    end
endmodule
